cc_handshake_rx: RTL and testbench

- Receiving endpoint of a 4-phase req/ack data handshake. The initiator sits in a foreign clock domain; this block sits entirely in the local `clk` domain.
- Synchronizes the incoming `req_i` level and captures the bundled `data_i`.
- Presents the captured word on a local valid/ready stream.
- Returns `ack_o` only after the word has been consumed, so the sender cannot overrun the receiver.
- Adds protocol-violation detection and a transfer counter for debug.

---
 rtl/cc_hs_pkg.sv | 24 ++
 rtl/cc_handshake_rx_sync_bits.sv | 24 ++
 rtl/cc_handshake_rx.sv | 125 ++++++++++++
 tb/tb_cc_handshake_rx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_hs_pkg.sv
// Shared types and constants for the cc_handshake_rx receiver and its synchronizer.
package cc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } hs_state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Keep an out-of-range stage request inside the legal window.
  function automatic int sync_stages_clamp(input int n);
    if (n < SYNC_STAGES_MIN) begin
      return SYNC_STAGES_MIN;
    end else if (n > SYNC_STAGES_MAX) begin
      return SYNC_STAGES_MAX;
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/cc_handshake_rx_sync_bits.sv
// N-stage single-bit level synchronizer; the output is the last flop of the chain.
module sync_bits #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_r;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[N-2:0], d};
    end
  end

  assign q = chain_r[N-1];

endmodule

// File: rtl/cc_handshake_rx.sv
// Receiving end of a 4-phase req/ack handshake: captures the bundled word into a
// local valid/ready stream and only acknowledges once the word has been consumed.
module cc_handshake_rx
  import cc_hs_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               ack_o,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               err_o,
  output logic [COUNT_W-1:0] xfer_count
);

  localparam int SYNC_N = sync_stages_clamp(SYNC_STAGES);

  logic               req_s;
  hs_state_e          state_r, state_s;
  logic               ack_r, ack_s;
  logic               valid_r, valid_s;
  logic [DATA_W-1:0]  data_r, data_s;
  logic               err_r, err_s;
  logic               early_r, early_s;
  logic [COUNT_W-1:0] cnt_r, cnt_s;

  sync_bits #(.N(SYNC_N)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (req_i),
    .q     (req_s)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      valid_r <= 1'b0;
      data_r  <= '0;
      err_r   <= 1'b0;
      early_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      ack_r   <= ack_s;
      valid_r <= valid_s;
      data_r  <= data_s;
      err_r   <= err_s;
      early_r <= early_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s = state_r;
    ack_s   = ack_r;
    valid_s = valid_r;
    data_s  = data_r;
    err_s   = 1'b0;
    early_s = early_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        // Level-triggered: IDLE is only re-entered after req_s has fallen.
        if (req_s) begin
          data_s  = data_i;
          valid_s = 1'b1;
          early_s = 1'b0;
          state_s = HOLD;
        end else begin
          state_s = IDLE;
        end
      end
      HOLD: begin
        // Sender withdrew req before ack: flag once, still deliver the word.
        if (!req_s && !early_r) begin
          err_s   = 1'b1;
          early_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
        if (valid_r && out_ready) begin
          valid_s = 1'b0;
          ack_s   = 1'b1;
          cnt_s   = cnt_r + COUNT_W'(1);
          early_s = 1'b0;
          state_s = ACK;
        end else begin
          state_s = HOLD;
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_s   = 1'b0;
          state_s = IDLE;
        end else begin
          state_s = ACK;
        end
      end
      default: begin
        ack_s   = 1'b0;
        valid_s = 1'b0;
        early_s = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  assign ack_o      = ack_r;
  assign out_valid  = valid_r;
  assign out_data   = data_r;
  assign err_o      = err_r;
  assign xfer_count = cnt_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_cc_handshake_rx.sv
// Scoreboard bench: the sender pushes expected words, a negedge monitor pops and
// compares on every accepted word and also drains timed point-checks from the stimulus.
module tb_cc_handshake_rx;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic        clk, rst_n, req, rdy, sel;
  logic [7:0]  data;
  logic        req_a, req_b, rdy_a, rdy_b;
  logic        ack_a, ack_b, valid_a, valid_b, busy_a, busy_b, err_a, err_b;
  logic [7:0]  out_data_a, out_data_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  logic        ack_mux;

  logic [7:0]  exp_q[$];
  chk_t        chk_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  chk_t        mon_c;
  logic [7:0]  mon_exp;

  assign req_a   = req & ~sel;
  assign req_b   = req & sel;
  assign rdy_a   = rdy & ~sel;
  assign rdy_b   = rdy & sel;
  assign ack_mux = sel ? ack_b : ack_a;

  cc_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .COUNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req_a), .data_i(data), .ack_o(ack_a),
    .out_valid(valid_a), .out_data(out_data_a), .out_ready(rdy_a),
    .busy(busy_a), .err_o(err_a), .xfer_count(cnt_a)
  );

  cc_handshake_rx #(.DATA_W(8), .SYNC_STAGES(2), .COUNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req_b), .data_i(data), .ack_o(ack_b),
    .out_valid(valid_b), .out_data(out_data_b), .out_ready(rdy_b),
    .busy(busy_b), .err_o(err_b), .xfer_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain point-checks, then score any word accepted at the coming edge.
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      n_vec++;
      if (mon_c.act !== mon_c.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, want %0h", mon_c.name, mon_c.act, mon_c.exp);
      end
    end
    if ((valid_a && rdy_a) || (valid_b && rdy_b)) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL word: got %0h, want none pending", sel ? out_data_b : out_data_a);
      end else begin
        mon_exp = exp_q.pop_front();
        if ((sel ? out_data_b : out_data_a) !== mon_exp) begin
          n_err++;
          $display("FAIL word: got %0h, want %0h", sel ? out_data_b : out_data_a, mon_exp);
        end
      end
    end
  end

  task automatic probe(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_q.push_back('{nm, a, e});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic level, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ack_mux == level) begin
        ok = 1'b1;
        break;
      end
      step();
      if (rdy !== 1'bx && nm == "rnd") rdy = 1'($urandom_range(0, 1));
    end
    if (!ok) probe({"timeout_", nm}, 32'd0, 32'd1);
  endtask

  task automatic xfer(input logic [7:0] d, input bit rnd);
    exp_q.push_back(d);
    data = d;
    req  = 1'b1;
    wait_ack(1'b1, rnd ? "rnd" : "ack_rise");
    req = 1'b0;
    wait_ack(1'b0, "ack_fall");
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; rdy = 1'b0; sel = 1'b0; data = 8'h00;
    repeat (2) step();
    probe("rst_valid", 32'(valid_a), 32'd0);
    probe("rst_ack",   32'(ack_a),   32'd0);
    probe("rst_busy",  32'(busy_a),  32'd0);
    probe("rst_err",   32'(err_a),   32'd0);
    probe("rst_cnt",   32'(cnt_a),   32'd0);
    rst_n = 1'b1;
    step();

    // Basic transfer, latency and ack timing.
    rdy = 1'b1; data = 8'hA5; exp_q.push_back(8'hA5); req = 1'b1;
    step(); probe("t1_valid_e1", 32'(valid_a), 32'd0);
    step(); probe("t1_valid_e2", 32'(valid_a), 32'd0);
    step(); probe("t1_valid_e3", 32'(valid_a), 32'd1);
    probe("t1_data_e3", 32'(out_data_a), 32'hA5);
    probe("t1_busy_e3", 32'(busy_a), 32'd1);
    step(); probe("t1_ack_e4", 32'(ack_a), 32'd1);
    probe("t1_valid_e4", 32'(valid_a), 32'd0);
    req = 1'b0;
    step(); probe("t1_ack_e5", 32'(ack_a), 32'd1);
    step(); probe("t1_ack_e6", 32'(ack_a), 32'd1);
    step(); probe("t1_ack_e7", 32'(ack_a), 32'd0);
    probe("t1_busy", 32'(busy_a), 32'd0);
    probe("t1_cnt",  32'(cnt_a),  32'd1);

    // Backpressure: word held, no ack, until out_ready.
    rdy = 1'b0; data = 8'h3C; exp_q.push_back(8'h3C); req = 1'b1;
    repeat (3) step();
    probe("t2_valid", 32'(valid_a), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      probe("t2_hold_valid", 32'(valid_a),    32'd1);
      probe("t2_hold_data",  32'(out_data_a), 32'h3C);
      probe("t2_hold_ack",   32'(ack_a),      32'd0);
    end
    rdy = 1'b1;
    step(); probe("t2_ack", 32'(ack_a), 32'd1);
    req = 1'b0;
    wait_ack(1'b0, "t2_fall");
    probe("t2_cnt", 32'(cnt_a), 32'd2);

    // Early req drop while held: single err pulse, word still delivered.
    rdy = 1'b0; data = 8'h5A; exp_q.push_back(8'h5A); req = 1'b1;
    repeat (3) step();
    probe("t3_valid", 32'(valid_a), 32'd1);
    req = 1'b0;
    step(); probe("t3_err_e4", 32'(err_a), 32'd0);
    step(); probe("t3_err_e5", 32'(err_a), 32'd0);
    step(); probe("t3_err_e6", 32'(err_a), 32'd1);
    step(); probe("t3_err_e7", 32'(err_a), 32'd0);
    probe("t3_valid_e7", 32'(valid_a), 32'd1);
    step(); probe("t3_err_e8", 32'(err_a), 32'd0);
    rdy = 1'b1;
    step(); probe("t3_ack_e9",  32'(ack_a), 32'd1);
    step(); probe("t3_ack_e10", 32'(ack_a), 32'd0);
    probe("t3_busy", 32'(busy_a), 32'd0);
    probe("t3_cnt",  32'(cnt_a),  32'd3);

    // Back-to-back with random out_ready.
    rdy = 1'b0;
    for (int i = 0; i < 300; i++) xfer(8'($urandom), 1'b1);
    probe("t4_cnt", 32'(cnt_a), 32'd303);

    // Counter wrap on the 4-bit instance.
    rdy = 1'b0; step(); sel = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 17; i++) xfer(8'(i * 7 + 1), 1'b0);
    probe("t5_cnt_wrap", 32'(cnt_b),  32'd1);
    probe("t5_busy_b",   32'(busy_b), 32'd0);
    probe("t5_err_b",    32'(err_b),  32'd0);
    probe("t5_cnt_a",    32'(cnt_a),  32'd303);
    rdy = 1'b0; step(); sel = 1'b0;

    // Reset in HOLD discards the word; a fresh capture follows release.
    data = 8'hC3; req = 1'b1;
    repeat (3) step();
    probe("t6_valid_pre", 32'(valid_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    probe("t6_rst_valid", 32'(valid_a), 32'd0);
    probe("t6_rst_ack",   32'(ack_a),   32'd0);
    probe("t6_rst_busy",  32'(busy_a),  32'd0);
    probe("t6_rst_cnt",   32'(cnt_a),   32'd0);
    step();
    rst_n = 1'b1;
    exp_q.push_back(8'hC3);
    step();
    step(); probe("t6_valid_e2", 32'(valid_a), 32'd0);
    step(); probe("t6_valid_e3", 32'(valid_a), 32'd1);
    probe("t6_data", 32'(out_data_a), 32'hC3);
    rdy = 1'b1;
    step(); probe("t6_ack", 32'(ack_a), 32'd1);
    req = 1'b0;
    wait_ack(1'b0, "t6_fall");
    probe("t6_cnt", 32'(cnt_a), 32'd1);
    probe("words_left", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 20 && chk_q.size() > 0; i++) step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
